// File: rtl/chain_pipeline_pkg.sv
// chain_pipeline_pkg: shared operation encoding and the per-stage operator.
// The operator works on OP_MAX_W-bit operands; callers zero-extend their
// WIDTH-bit data and keep the low WIDTH bits of the result. The carry out of
// ADD therefore falls away, which gives modulo 2^WIDTH arithmetic.
package chain_pipeline_pkg;

  localparam int unsigned OP_MAX_W = 64;

  typedef enum logic [1:0] {
    OP_XOR = 2'd0,
    OP_AND = 2'd1,
    OP_OR  = 2'd2,
    OP_ADD = 2'd3
  } op_e;

  function automatic logic [OP_MAX_W-1:0] op_apply(input op_e                 sel,
                                                   input logic [OP_MAX_W-1:0] a,
                                                   input logic [OP_MAX_W-1:0] b);
    logic [OP_MAX_W-1:0] r;
    case (sel)
      OP_XOR:  r = a ^ b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_ADD:  r = a + b;
      default: r = a ^ b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/chain_pipeline_if.sv
// chain_pipeline_if: input/output handshake buses, feedthrough and beat count.
// master = traffic source/sink side, slave = the chain_pipeline block.
interface chain_pipeline_if #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8
);
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic [1:0]       mode;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_ready;
  logic             in_ft;
  logic             out_ft;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in0, in1, mode, in_valid, out_ready, in_ft,
    input  in_ready, out, out_valid, out_ft, out_count
  );

  modport slave (
    input  in0, in1, mode, in_valid, out_ready, in_ft,
    output in_ready, out, out_valid, out_ft, out_count
  );

endinterface

// File: rtl/chain_stage.sv
// chain_stage: one registered stage of the chain. Holds a valid bit, the
// stage result op(up_data, in1) and the beat's in1/mode for the next stage.
// All four operators are commutative, so op(in0,in1) at stage 0 and
// op(in1,x) further down are the same hardware.
module chain_stage
  import chain_pipeline_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid_i,
  input  logic [WIDTH-1:0] up_data_i,
  input  logic [WIDTH-1:0] up_in1_i,
  input  op_e              up_mode_i,
  output logic             ready_o,
  input  logic             down_ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] in1_o,
  output op_e              mode_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [WIDTH-1:0] in1_q,   in1_d;
  op_e              mode_q,  mode_d;

  logic                advance;
  logic [OP_MAX_W-1:0] a_ext;
  logic [OP_MAX_W-1:0] b_ext;
  logic [OP_MAX_W-1:0] op_full;
  logic [WIDTH-1:0]    op_res;
  logic                op_carry_unused;

  // stage moves when empty or when the stage below takes its beat this cycle
  assign advance = !valid_q || down_ready_i;
  assign ready_o = advance;

  // zero-extend operands to the operator width
  always_comb begin
    a_ext = '0;
    b_ext = '0;
    a_ext[WIDTH-1:0] = up_data_i;
    b_ext[WIDTH-1:0] = up_in1_i;
  end

  assign op_full         = op_apply(up_mode_i, a_ext, b_ext);
  assign op_res          = op_full[WIDTH-1:0];
  assign op_carry_unused = ^op_full;

  // next state: load a new beat (or a bubble) on advance, otherwise hold
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    in1_d   = in1_q;
    mode_d  = mode_q;
    if (advance) begin
      valid_d = up_valid_i;
      if (up_valid_i) begin
        data_d = op_res;
        in1_d  = up_in1_i;
        mode_d = up_mode_i;
      end
    end
  end

  // stage registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      in1_q   <= '0;
      mode_q  <= OP_XOR;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      in1_q   <= in1_d;
      mode_q  <= mode_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign in1_o   = in1_q;
  assign mode_o  = mode_q;

endmodule

// File: rtl/chain_pipeline.sv
// chain_pipeline: DEPTH chained operator stages with valid/ready flow control,
// an output beat counter and a feedthrough bit.
// Build option CHAIN_PIPELINE_FT_REG_EN: when defined, out_ft is in_ft delayed
// by FT_DEPTH reset-to-0 flops; when undefined, out_ft is a direct wire.
// WIDTH is limited to chain_pipeline_pkg::OP_MAX_W bits.
module chain_pipeline
  import chain_pipeline_pkg::*;
#(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned FT_DEPTH = 2,
  parameter int unsigned CNT_W    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  chain_pipeline_if.slave bus
);

  // index k is the input of stage k; index DEPTH is the pipeline output
  logic             v_w   [DEPTH+1];
  logic [WIDTH-1:0] d_w   [DEPTH+1];
  logic [WIDTH-1:0] s_w   [DEPTH+1];
  op_e              m_w   [DEPTH+1];
  logic             rdy_w [DEPTH+1];
  logic             sideband_unused;

  logic [CNT_W-1:0] out_count_q, out_count_d;

  assign v_w[0]       = bus.in_valid;
  assign d_w[0]       = bus.in0;
  assign s_w[0]       = bus.in1;
  assign m_w[0]       = op_e'(bus.mode);
  assign rdy_w[DEPTH] = bus.out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    chain_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk          (clk),
      .rst_n        (rst_n),
      .up_valid_i   (v_w[k]),
      .up_data_i    (d_w[k]),
      .up_in1_i     (s_w[k]),
      .up_mode_i    (m_w[k]),
      .ready_o      (rdy_w[k]),
      .down_ready_i (rdy_w[k+1]),
      .valid_o      (v_w[k+1]),
      .data_o       (d_w[k+1]),
      .in1_o        (s_w[k+1]),
      .mode_o       (m_w[k+1])
    );
  end

  // the last stage's carried in1/mode have no consumer
  assign sideband_unused = ^{s_w[DEPTH], m_w[DEPTH]};

  assign bus.in_ready  = rdy_w[0];
  assign bus.out_valid = v_w[DEPTH];
  assign bus.out       = d_w[DEPTH];

  // count accepted output beats, wrapping naturally at 2^CNT_W
  always_comb begin
    out_count_d = out_count_q;
    if (bus.out_valid && bus.out_ready) begin
      out_count_d = out_count_q + 1'b1;
    end
  end

  // output beat counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_count_q <= '0;
    end else begin
      out_count_q <= out_count_d;
    end
  end

  assign bus.out_count = out_count_q;

`ifdef CHAIN_PIPELINE_FT_REG_EN
  logic [FT_DEPTH-1:0] ft_q, ft_d;

  // shift in_ft along the free-running delay line
  always_comb begin
    ft_d    = '0;
    ft_d[0] = bus.in_ft;
    for (int unsigned i = 1; i < FT_DEPTH; i++) begin
      ft_d[i] = ft_q[i-1];
    end
  end

  // feedthrough delay flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ft_q <= '0;
    end else begin
      ft_q <= ft_d;
    end
  end

  assign bus.out_ft = ft_q[FT_DEPTH-1];
`else
  localparam int unsigned FT_DEPTH_UNUSED = FT_DEPTH;
  assign bus.out_ft = bus.in_ft;
`endif

endmodule

// File: tb/tb_chain_pipeline.sv
// tb_chain_pipeline: scoreboard bench for chain_pipeline (WIDTH=4, DEPTH=4,
// FT_DEPTH=2, CNT_W=2). Inputs change 1 time unit after the rising edge;
// everything is observed on the falling edge.
module tb_chain_pipeline;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 2;

  logic clk;
  logic rst_n;

  chain_pipeline_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  chain_pipeline #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .FT_DEPTH (2),
    .CNT_W    (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  logic [3:0]  sb [$];
  int unsigned acc_cnt = 0;
  int unsigned out_tot = 0;
  bit          hold_v  = 0;
  logic [3:0]  hold_d  = '0;
  logic [1:0]  ft_hist = '0;
  bit          rnd_on  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // one operator application, straight from the operation table
  function automatic int unsigned ref_op(input logic [1:0] m, input int unsigned a,
                                         input int unsigned b);
    int unsigned r;
    case (m)
      2'd0:    r = a ^ b;
      2'd1:    r = a & b;
      2'd2:    r = a | b;
      default: r = (a + b) % 16;
    endcase
    return r;
  endfunction

  // x0 = op(in0,in1); xk = op(in1, x(k-1)); result is x(DEPTH-1)
  function automatic logic [3:0] ref_chain(input logic [3:0] a, input logic [3:0] b,
                                           input logic [1:0] m);
    int unsigned x;
    x = ref_op(m, int'(a), int'(b));
    for (int k = 1; k < int'(DEPTH); k++) x = ref_op(m, int'(b), x);
    return 4'(x);
  endfunction

  // free-running random feedthrough input
  initial begin
    bus.in_ft = 1'b0;
    forever begin
      @(posedge clk);
      #1 bus.in_ft = 1'($urandom_range(1));
    end
  end

  // monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        hold_v  = 0;
        out_tot = 0;
`ifdef CHAIN_PIPELINE_FT_REG_EN
        ft_hist = '0;
        chk("out_ft_rst", 32'(bus.out_ft), 32'(1'b0));
`else
        chk("out_ft", 32'(bus.out_ft), 32'(bus.in_ft));
`endif
      end else begin
`ifdef CHAIN_PIPELINE_FT_REG_EN
        chk("out_ft", 32'(bus.out_ft), 32'(ft_hist[1]));
        ft_hist = {ft_hist[0], bus.in_ft};
`else
        chk("out_ft", 32'(bus.out_ft), 32'(bus.in_ft));
`endif
        chk("out_count", 32'(bus.out_count), 32'(out_tot % 4));
        if (hold_v) begin
          chk("hold_valid", 32'(bus.out_valid), 32'(1'b1));
          chk("hold_data", 32'(bus.out), 32'(hold_d));
        end
        if (bus.out_valid && bus.out_ready) begin
          chk("sb_nonempty", 32'(sb.size() != 0), 32'(1'b1));
          if (sb.size() != 0) chk("out_data", 32'(bus.out), 32'(sb.pop_front()));
          out_tot++;
        end
        hold_v = bus.out_valid && !bus.out_ready;
        hold_d = bus.out;
        if (bus.in_valid && bus.in_ready) begin
          sb.push_back(ref_chain(bus.in0, bus.in1, bus.mode));
          acc_cnt++;
        end
      end
    end
  end

  // offer one beat from posedge+1; returns at posedge+1 after its transfer edge
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [1:0] m);
    bit got;
    got = 0;
    bus.in0      = a;
    bus.in1      = b;
    bus.mode     = m;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1");
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // send one beat into an empty pipeline and measure cycles until out_valid
  task automatic lat_beat(input logic [3:0] a, input logic [3:0] b, input logic [1:0] m,
                          input string nm, input logic [3:0] exp_out);
    int unsigned lat;
    send(a, b, m);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) break;
    end
    chk({nm, "_latency"}, lat, 32'(DEPTH));
    chk({nm, "_out"}, 32'(bus.out), 32'(exp_out));
    @(posedge clk);
    #1;
  endtask

  task automatic rand_send();
    send(4'($urandom), 4'($urandom), 2'($urandom));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned acc0;
    int unsigned w;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in0       = '0;
    bus.in1       = '0;
    bus.mode      = '0;
    bus.out_ready = 1'b0;

    #3;
    chk("rst_out_valid", 32'(bus.out_valid), 32'(1'b0));
    chk("rst_out", 32'(bus.out), 32'(4'h0));
    chk("rst_out_count", 32'(bus.out_count), 32'(2'd0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 32'(bus.in_ready), 32'(1'b1));
    chk("rel_out_valid", 32'(bus.out_valid), 32'(1'b0));
    @(posedge clk);
    #1 bus.out_ready = 1'b1;

    // directed operator checks
    lat_beat(4'h3, 4'h5, 2'd0, "xor", 4'h3);
    lat_beat(4'h1, 4'h2, 2'd3, "add", 4'h9);
    lat_beat(4'hF, 4'hF, 2'd3, "add_wrap", 4'hB);
    lat_beat(4'hC, 4'hA, 2'd1, "and", 4'h8);
    lat_beat(4'h1, 4'h2, 2'd2, "or", 4'h3);

    // backpressure: four fit, fifth waits, then all drain back-to-back
    bus.out_ready = 1'b0;
    acc0 = acc_cnt;
    fork
      begin
        for (int i = 0; i < 5; i++) rand_send();
      end
      begin
        repeat (10) @(negedge clk);
        chk("bp_accepted", acc_cnt - acc0, 32'd4);
        chk("bp_in_ready_full", 32'(bus.in_ready), 32'(1'b0));
        chk("bp_out_valid_full", 32'(bus.out_valid), 32'(1'b1));
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          if (i == 0) chk("bp_in_ready_simul", 32'(bus.in_ready), 32'(1'b1));
          chk("bp_drain_valid", 32'(bus.out_valid), 32'(1'b1));
        end
        @(negedge clk);
        chk("bp_drained", 32'(bus.out_valid), 32'(1'b0));
      end
    join
    @(posedge clk);
    #1;

    // reset with beats in flight
    bus.out_ready = 1'b0;
    rand_send();
    rand_send();
    repeat (5) @(negedge clk);
    chk("mid_out_valid_pre", 32'(bus.out_valid), 32'(1'b1));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'(1'b0));
    chk("mid_rst_out", 32'(bus.out), 32'(4'h0));
    chk("mid_rst_out_count", 32'(bus.out_count), 32'(2'd0));
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rel_in_ready", 32'(bus.in_ready), 32'(1'b1));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("mid_no_stale", 32'(bus.out_valid), 32'(1'b0));
    end
    @(posedge clk);
    #1;
    lat_beat(4'h6, 4'h9, 2'd0, "post_rst", ref_chain(4'h6, 4'h9, 2'd0));

    // counter: five output transfers since reset wrap a 2-bit count to 1
    for (int i = 0; i < 4; i++) rand_send();
    repeat (8) @(negedge clk);
    chk("count_wrap", 32'(bus.out_count), 32'(2'd1));
    @(posedge clk);
    #1;

    // randomized traffic with random backpressure
    rnd_on = 1;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          rand_send();
          if ($urandom_range(3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        rnd_on = 0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1 bus.out_ready = 1'($urandom_range(1));
        end
      end
    join
    bus.out_ready = 1'b1;
    w = 0;
    while (w < 100 && (sb.size() != 0 || bus.out_valid)) begin
      @(negedge clk);
      w++;
    end
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);
    chk("drain_out_valid", 32'(bus.out_valid), 32'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/chain_pipeline.md
CHAIN_PIPELINE -- requirements
Module: chain_pipeline

Interface
REQ-001 SHALL have parameter WIDTH, default 1, data bits per operand (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, number of chained stages (>=1).
REQ-003 SHALL have parameter FT_DEPTH, default 2, feedthrough register stages (>=1).
REQ-004 SHALL have parameter CNT_W, default 8, output beat counter width (>=1).
REQ-005 SHALL use one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  async active-low reset.
REQ-008 in0  input  WIDTH  first operand.
REQ-009 in1  input  WIDTH  side operand, carried with the beat.
REQ-010 mode  input  2  per-beat op select: 0 XOR, 1 AND, 2 OR, 3 ADD.
REQ-011 in_valid / in_ready  input / output  1  input handshake.
REQ-012 out  output  WIDTH  chain result.
REQ-013 out_valid / out_ready  output / input  1  output handshake.
REQ-014 in_ft  input  1  feedthrough in.
REQ-015 out_ft  output  1  feedthrough out.
REQ-016 out_count  output  CNT_W  accepted output beats.

Function
REQ-017 Beat transfers at input when in_valid&&in_ready, at output when out_valid&&out_ready, both sampled at rising clk.
REQ-018 Stage 0 SHALL register x0 = op(in0, in1); stage k>0 SHALL register xk = op(in1, x(k-1)), using the beat's own in1 and mode.
REQ-019 in1 and mode SHALL travel with the beat through all stages; mode changes between beats take effect per beat.
REQ-020 ADD SHALL be modulo 2^WIDTH, carry discarded.
REQ-021 out SHALL equal x(DEPTH-1); out_valid SHALL be the last stage's valid bit.
REQ-022 Latency SHALL be DEPTH cycles from input transfer to out_valid with out_ready held high.
REQ-023 Each stage SHALL advance when it is empty or its downstream stage advances in the same cycle; full throughput of one beat/cycle.
REQ-024 in_ready SHALL be high when stage 0 is empty or advancing; combinational from out_ready is permitted.
REQ-025 Pipeline full (DEPTH beats held, out_ready low): in_ready SHALL be 0; no beat lost, duplicated or reordered.
REQ-026 Simultaneous input and output transfer on a full pipeline SHALL be accepted in the same cycle.
REQ-027 out and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-028 out_count SHALL increment by 1 per output transfer, wrapping 2^CNT_W-1 -> 0.
REQ-029 Feedthrough path SHALL be independent of the handshake and free-running.

Reset
REQ-030 Asserting rst_n low SHALL immediately clear all stage valids, out_valid=0, out=0, out_count=0, out_ft=0, in_ready=1 after release.
REQ-031 Reset mid-operation SHALL discard all in-flight beats; first beat after release sees latency DEPTH.

Configuration
REQ-032 Macro CHAIN_PIPELINE_FT_REG_EN defined: out_ft SHALL be in_ft delayed FT_DEPTH cycles through reset-to-0 flops.
REQ-033 Macro undefined: out_ft SHALL equal in_ft combinationally, FT_DEPTH unused, no feedthrough flops.

Structure
REQ-034 Package chain_pipeline_pkg SHALL hold op enum typedef (XOR, AND, OR, ADD) and op function.
REQ-035 One sub-module chain_stage SHALL implement one registered stage (valid, data, in1, mode), instanced DEPTH times via generate.

Verification (WIDTH=4, DEPTH=4, CNT_W=2 unless stated)
REQ-036 XOR: in0=0x3, in1=0x5, out_ready=1 -> out=0x3, out_valid high exactly 4 cycles after transfer.
REQ-037 ADD: in0=0x1, in1=0x2 -> out=0x9; in0=0xF, in1=0xF -> out=0xB (wrap).
REQ-038 Backpressure: out_ready=0, offer 5 beats -> 4 accepted, in_ready=0 on 5th; raise out_ready -> all 5 emerge in order, one per cycle.
REQ-039 Reset mid-stream: 2 beats in flight, pulse rst_n low -> out_valid=0 immediately, no stale beats after release.
REQ-040 Counter: 5 output transfers -> out_count=1; FT_REG_EN defined, in_ft pulse -> out_ft pulse 2 cycles later; undefined -> same cycle.
